// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader.
//   ld_state_t     : loader FSM state encoding
//   BYTES_PER_WORD : bytes per instruction word
//   get_byte       : big-endian byte select (k=0 is the MSB)
package cpu_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT_WORD,
    LD_WR0,
    LD_WR1,
    LD_WR2,
    LD_WR3,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: accepts 32-bit words on a valid/ready stream
// and writes them big-endian, one byte per cycle, into the byte-wide
// instruction memory. Holds the CPU stalled while a load is in progress.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begins a load at byte address 0 (IDLE/DONE/ERROR only)
//   in_valid/in_word/in_last/in_ready : word stream from the program source
//   wr_en/wr_addr/wr_data : byte write port into the instruction memory
//   cpu_stall         : high while loading
//   done/overflow     : load finished / program exceeded DEPTH (held)
//   word_count        : words fully written in the current or last load
module inst_mem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_stall,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

  // Pointer carries one extra bit so that "memory full" (ptr == DEPTH) is representable.
  localparam logic [ADDR_W:0]   PTR_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   PTR_STEP = (ADDR_W+1)'(BYTES_PER_WORD);
  localparam logic [ADDR_W-2:0] CNT_ONE  = (ADDR_W-1)'(1);

  ld_state_t         r_state;
  ld_state_t         w_next;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W-2:0] r_count;
  logic [31:0]       r_word;
  logic              r_last;

  logic              w_space;
  logic              w_hs;
  logic              w_restart;
  logic              w_wr;
  logic [1:0]        w_k;

  assign w_space   = (r_ptr < PTR_FULL);
  assign w_hs      = (r_state == LD_WAIT_WORD) && w_space && in_valid;
  assign w_restart = start && (r_state inside {LD_IDLE, LD_DONE, LD_ERROR});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) w_next = LD_WAIT_WORD;
      end
      LD_WAIT_WORD: begin
        if (!w_space)      w_next = LD_ERROR;
        else if (in_valid) w_next = LD_WR0;
      end
      LD_WR0:  w_next = LD_WR1;
      LD_WR1:  w_next = LD_WR2;
      LD_WR2:  w_next = LD_WR3;
      LD_WR3:  w_next = r_last ? LD_DONE : LD_WAIT_WORD;
      default: w_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_word  <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_restart) begin
        r_ptr   <= '0;
        r_count <= '0;
      end else if (r_state == LD_WR3) begin
        r_ptr   <= r_ptr + PTR_STEP;
        r_count <= r_count + CNT_ONE;
      end
      if (w_hs) begin
        r_word <= in_word;
        r_last <= in_last;
      end
    end
  end

  // All outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    w_wr = 1'b0;
    w_k  = 2'd0;
    case (r_state)
      LD_WR0:  begin w_wr = 1'b1; w_k = 2'd0; end
      LD_WR1:  begin w_wr = 1'b1; w_k = 2'd1; end
      LD_WR2:  begin w_wr = 1'b1; w_k = 2'd2; end
      LD_WR3:  begin w_wr = 1'b1; w_k = 2'd3; end
      default: begin w_wr = 1'b0; w_k = 2'd0; end
    endcase

    in_ready  = (r_state == LD_WAIT_WORD) && w_space;
    wr_en     = w_wr;
    wr_addr   = w_wr ? (r_ptr[ADDR_W-1:0] + ADDR_W'(w_k)) : '0;
    wr_data   = w_wr ? get_byte(r_word, w_k) : '0;
    cpu_stall = (r_state inside {LD_WAIT_WORD, LD_WR0, LD_WR1, LD_WR2, LD_WR3});
    done      = (r_state == LD_DONE);
    overflow  = (r_state == LD_ERROR);
  end

  assign word_count = r_count;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_word = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cpu_stall;
  logic              done;
  logic              overflow;
  logic [ADDR_W-2:0] word_count;

  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] mem [DEPTH];
  int         passed = 0;
  int         total  = 0;
  int         exp_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rd(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Monitor: every byte write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
      mem[wr_addr] = wr_data;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    int n;
    for (int k = 0; k < 4; k++)
      sb.push_back('{addr: ADDR_W'((exp_ptr + k) % DEPTH), data: 8'(w >> (24 - 8 * k))});
    exp_ptr += 4;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL handshake_timeout: in_ready=0 after %0d cycles, expected 1", n);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || overflow) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int gap;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_wr_en",      32'(wr_en),      32'd0);
    check("rst_wr_addr",    32'(wr_addr),    32'd0);
    check("rst_wr_data",    32'(wr_data),    32'd0);
    check("rst_cpu_stall",  32'(cpu_stall),  32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word with last
    pulse_start();
    check("t1_stall_on", 32'(cpu_stall), 32'd1);
    check("t1_ready",    32'(in_ready),  32'd1);
    send_word(32'h00A00093, 1'b1);
    wait_end();
    check("t1_done",     32'(done),       32'd1);
    check("t1_overflow", 32'(overflow),   32'd0);
    check("t1_count",    32'(word_count), 32'd1);
    check("t1_stall_off",32'(cpu_stall),  32'd0);
    check("t1_readback", rd(0),           32'h00A00093);

    // Three words; in_ready low for exactly 4 cycles after each handshake
    pulse_start();
    send_word(32'h11223344, 1'b0);
    measure_gap(gap);
    check("t2_gap1", 32'(gap), 32'd4);
    send_word(32'h55667788, 1'b0);
    measure_gap(gap);
    check("t2_gap2", 32'(gap), 32'd4);
    send_word(32'h99AABBCC, 1'b1);
    wait_end();
    check("t2_byte4",  32'(mem[4]),     32'h55);
    check("t2_byte11", 32'(mem[11]),    32'hCC);
    check("t2_count",  32'(word_count), 32'd3);
    check("t2_done",   32'(done),       32'd1);

    // Source idle for 7 cycles between words
    pulse_start();
    send_word(32'hDEADBEEF, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t3_idle_wr_en", 32'(wr_en),     32'd0);
      check("t3_idle_stall", 32'(cpu_stall), 32'd1);
    end
    send_word(32'h0BADF00D, 1'b1);
    wait_end();
    check("t3_readback", rd(4),           32'h0BADF00D);
    check("t3_count",    32'(word_count), 32'd2);

    // Fill memory without in_last -> overflow
    pulse_start();
    for (int i = 0; i < 256; i++) send_word(32'(i) * 32'h01010101 ^ 32'hA5000000, 1'b0);
    wait_end();
    check("t4_overflow", 32'(overflow),   32'd1);
    check("t4_done",     32'(done),       32'd0);
    check("t4_count",    32'(word_count), 32'd256);
    check("t4_last_wd",  rd(1020),        32'(255) * 32'h01010101 ^ 32'hA5000000);
    repeat (3) @(negedge clk);
    check("t4_ready_low", 32'(in_ready),  32'd0);
    check("t4_stall_off", 32'(cpu_stall), 32'd0);

    // Fill memory exactly with in_last on word 256 -> done
    pulse_start();
    check("t4b_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 256; i++) send_word(32'h5A5A0000 + 32'(i), (i == 255));
    wait_end();
    check("t4b_done",     32'(done),       32'd1);
    check("t4b_overflow", 32'(overflow),   32'd0);
    check("t4b_count",    32'(word_count), 32'd256);
    check("t4b_last_wd",  rd(1020),        32'h5A5A00FF);

    // Reset during WR2 of word 2
    pulse_start();
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_wr_en",   32'(wr_en),      32'd0);
    check("t5_wr_addr", 32'(wr_addr),    32'd0);
    check("t5_wr_data", 32'(wr_data),    32'd0);
    check("t5_stall",   32'(cpu_stall),  32'd0);
    check("t5_count",   32'(word_count), 32'd0);
    check("t5_ready",   32'(in_ready),   32'd0);
    check("t5_kept",    32'(mem[6]),     32'h07);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    pulse_start();
    send_word(32'hCAFEF00D, 1'b1);
    wait_end();
    check("t5_readback", rd(0),           32'hCAFEF00D);
    check("t5_count2",   32'(word_count), 32'd1);

    // start during WR1 is ignored; start in DONE begins a new load
    pulse_start();
    send_word(32'h13579BDF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_stall_kept", 32'(cpu_stall), 32'd1);
    send_word(32'h2468ACE0, 1'b1);
    wait_end();
    check("t6_count", 32'(word_count), 32'd2);
    check("t6_done",  32'(done),       32'd1);
    check("t6_word2", rd(4),           32'h2468ACE0);
    pulse_start();
    check("t6_done_clr",  32'(done),       32'd0);
    check("t6_stall_new", 32'(cpu_stall),  32'd1);
    check("t6_count_clr", 32'(word_count), 32'd0);
    send_word(32'hFFFFFFFF, 1'b1);
    wait_end();
    check("t6_done2", 32'(done), 32'd1);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer side of the byte-addressed instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes them into the 8-bit-wide instruction memory array through a byte write port.
- Byte order is big-endian: byte at address a is word[31:24], a+1 is [23:16], a+2 is [15:8], a+3 is [7:0]. This matches the read-side concatenation.
- Sits between a program source (testbench, UART deframer or boot ROM) and the instruction memory, and holds the CPU in stall until loading completes.

Parameters:
DEPTH, 1024, instruction memory size in bytes; must be a multiple of 4.
ADDR_W, 10, byte address width, equal to clog2(DEPTH).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load at byte address 0.
in_valid  input  1  source has a word on in_word.
in_word  input  32  instruction word.
in_last  input  1  qualifies in_word as the final word of the program.
in_ready  output  1  loader accepts a word this cycle.
wr_en  output  1  byte write strobe to the instruction memory.
wr_addr  output  ADDR_W  byte address of the write.
wr_data  output  8  byte to write.
cpu_stall  output  1  high while a load is in progress.
done  output  1  load finished; held until the next start.
overflow  output  1  program exceeded DEPTH; held until the next start.
word_count  output  ADDR_W-1  number of words fully written in the current or last load.

Behaviour:
- Reset, applied asynchronously: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_stall=0, done=0, overflow=0, word_count=0; internal byte pointer=0.
- All outputs are decoded from registered state (Moore); there are no combinational paths from inputs to outputs.
- States: IDLE, WAIT_WORD, WR0, WR1, WR2, WR3, DONE, ERROR.
- IDLE/DONE/ERROR + start goes to WAIT_WORD. It clears ptr, word_count, done and overflow.
- start in any other state is ignored.
- WAIT_WORD:
  - in_ready=1 only when ptr < DEPTH.
  - A handshake (in_valid && in_ready) latches in_word and in_last, then goes to WR0.
  - If ptr == DEPTH, in_ready=0 and the next state is ERROR.
- WRk (k=0..3):
  - wr_en=1, wr_addr=ptr+k, wr_data = byte k of the latched word (k=0 is MSB).
  - Each WRk advances to the next state in one cycle.
- WR3 exit:
  - ptr += 4 and word_count += 1.
  - If the latched last flag is set, go to DONE; otherwise go to WAIT_WORD.
- Latency: handshake at edge N; bytes are written at edges N+1..N+4; in_ready is high again in the cycle after edge N+4. Throughput is one word per 5 cycles.
- cpu_stall=1 in WAIT_WORD and WR0..WR3; 0 in IDLE, DONE and ERROR.
- done=1 only in DONE; overflow=1 only in ERROR.
- in_valid during WR0..WR3 is not accepted; the source must hold the word (standard valid/ready).
- in_last on a word that exactly fills the memory (ptr becomes DEPTH) ends in DONE, not ERROR.
- Reset mid-write aborts immediately: wr_en drops asynchronously. Bytes already written remain in memory.
- Address arithmetic is unsigned ADDR_W+1 bits internally, so ptr==DEPTH is representable; wr_addr is truncated to ADDR_W.

Decomposition:
Shared package (cpu_pkg):
- loader state enum typedef.
- constant BYTES_PER_WORD=4.
- function get_byte(word, k) returning the big-endian byte.

Sub-modules: none needed. The FSM plus the ptr/word_count counters form one module. The instruction memory gains a synchronous byte write port (we, waddr, wdata) driven by this block.

Test Plan:
- Reset, then start, then 1 word 0x00A00093 with in_last -> writes (0,0x00),(1,0xA0),(2,0x00),(3,0x93) on consecutive cycles; done=1, word_count=1, cpu_stall 1->0; read port at address 0 returns 0x00A00093.
- 3 back-to-back words 0x11223344, 0x55667788, 0x99AABBCC (last on the third) -> in_ready gaps of exactly 4 cycles; byte 4=0x55, byte 11=0xCC; word_count=3.
- Source deasserts in_valid for 7 cycles between words -> loader waits in WAIT_WORD with wr_en=0 and cpu_stall=1; the resumed word is written at addresses 4..7.
- 256 words with no in_last (DEPTH=1024) -> last write at address 1023; in_ready stays 0 afterwards; overflow=1, done=0. A 256-word load with in_last on word 256 -> done=1, overflow=0.
- rst asserted during WR2 of word 2 -> wr_en=0 in the same cycle and all outputs at reset values; a new start then rewrites from address 0.
- start pulsed during WR1 -> ignored (ptr not cleared, load completes normally). start in DONE -> new load; done clears the next cycle.
